edf_irq_claimer: RTL and testbench

Core-side responder for the EDF interrupt controller's arbitration output: consumes the irq_valid/irq_id stream, presents the winner to the hart, and issues the one-cycle claim (ready) pulse when the hart acknowledges. Tracks a single in-service interrupt until the hart signals completion. Collects claim statistics (claim count, withdrawn count, maximum claim latency in mtime ticks) for software profiling.

---
 rtl/edf_irq_claimer.sv | 145 ++++++++++++++
 tb/tb_edf_irq_claimer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edf_irq_claimer.sv
// Core-side claim responder for the EDF interrupt controller: presents the winner to the hart,
// pulses the claim on ack, tracks one in-service interrupt and keeps claim statistics.
module edf_irq_claimer #(
  parameter int unsigned NrIrqs  = 4,
  parameter int unsigned TsWidth = 64,
  localparam int unsigned IdWidth = (NrIrqs > 1) ? $clog2(NrIrqs) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [TsWidth-1:0] mtime_i,
  input  logic               irq_valid_i,
  input  logic [IdWidth-1:0] irq_id_i,
  output logic               irq_ready_o,
  output logic               core_irq_o,
  output logic [IdWidth-1:0] core_irq_id_o,
  input  logic               core_ack_i,
  input  logic               core_done_i,
  output logic               in_service_o,
  output logic [IdWidth-1:0] active_id_o,
  input  logic               clear_stats_i,
  output logic [31:0]        claim_cnt_o,
  output logic [31:0]        withdraw_cnt_o,
  output logic [31:0]        lat_max_o
);

  typedef enum logic [1:0] {StIdle, StPend, StClaim, StService} state_e;

  state_e             state, state_next;
  logic               core_irq, core_irq_next;
  logic [IdWidth-1:0] core_irq_id, core_irq_id_next;
  logic               irq_ready, irq_ready_next;
  logic               in_service, in_service_next;
  logic [IdWidth-1:0] active_id, active_id_next;
  logic [TsWidth-1:0] t_arrive, t_arrive_next;
  logic [31:0]        claim_cnt, claim_cnt_next;
  logic [31:0]        withdraw_cnt, withdraw_cnt_next;
  logic [31:0]        lat_max, lat_max_next;

  logic [TsWidth-1:0] lat_diff;
  logic [31:0]        lat_sat;

  // Modular subtraction tolerates a single mtime wrap between arrival and ack.
  always_comb begin
    lat_diff = mtime_i - t_arrive;
    lat_sat  = (lat_diff > TsWidth'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : 32'(lat_diff);
  end

  always_comb begin
    state_next        = state;
    core_irq_next     = core_irq;
    core_irq_id_next  = core_irq_id;
    irq_ready_next    = 1'b0;
    in_service_next   = in_service;
    active_id_next    = active_id;
    t_arrive_next     = t_arrive;
    claim_cnt_next    = claim_cnt;
    withdraw_cnt_next = withdraw_cnt;
    lat_max_next      = lat_max;

    unique case (state)
      StIdle: begin
        if (irq_valid_i) begin
          state_next       = StPend;
          core_irq_next    = 1'b1;
          core_irq_id_next = irq_id_i;
          t_arrive_next    = mtime_i;
        end
      end
      StPend: begin
        if (core_ack_i) begin
          // The hart claims the ID it actually saw, not a same-cycle re-arbitration.
          state_next      = StClaim;
          core_irq_next   = 1'b0;
          irq_ready_next  = 1'b1;
          in_service_next = 1'b1;
          active_id_next  = core_irq_id;
          if (lat_sat > lat_max) begin
            lat_max_next = lat_sat;
          end
        end else if (!irq_valid_i) begin
          state_next        = StIdle;
          core_irq_next     = 1'b0;
          withdraw_cnt_next = withdraw_cnt + 32'd1;
        end else begin
          core_irq_id_next = irq_id_i;
        end
      end
      StClaim: begin
        state_next = StService;
      end
      StService: begin
        if (core_done_i) begin
          state_next      = StIdle;
          in_service_next = 1'b0;
          claim_cnt_next  = claim_cnt + 32'd1;
        end
      end
      default: begin
        state_next = StIdle;
      end
    endcase

    if (clear_stats_i) begin
      claim_cnt_next    = '0;
      withdraw_cnt_next = '0;
      lat_max_next      = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= StIdle;
      core_irq     <= 1'b0;
      core_irq_id  <= '0;
      irq_ready    <= 1'b0;
      in_service   <= 1'b0;
      active_id    <= '0;
      t_arrive     <= '0;
      claim_cnt    <= '0;
      withdraw_cnt <= '0;
      lat_max      <= '0;
    end else begin
      state        <= state_next;
      core_irq     <= core_irq_next;
      core_irq_id  <= core_irq_id_next;
      irq_ready    <= irq_ready_next;
      in_service   <= in_service_next;
      active_id    <= active_id_next;
      t_arrive     <= t_arrive_next;
      claim_cnt    <= claim_cnt_next;
      withdraw_cnt <= withdraw_cnt_next;
      lat_max      <= lat_max_next;
    end
  end

  assign irq_ready_o    = irq_ready;
  assign core_irq_o     = core_irq;
  assign core_irq_id_o  = core_irq_id;
  assign in_service_o   = in_service;
  assign active_id_o    = active_id;
  assign claim_cnt_o    = claim_cnt;
  assign withdraw_cnt_o = withdraw_cnt;
  assign lat_max_o      = lat_max;

endmodule

// File: tb/tb_edf_irq_claimer.sv
// Directed bench for edf_irq_claimer: hand-computed expectations checked with immediate asserts.
module tb_edf_irq_claimer;

  localparam int unsigned NrIrqs  = 4;
  localparam int unsigned TsWidth = 64;
  localparam int unsigned IdWidth = 2;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic [TsWidth-1:0] mtime_i;
  logic               irq_valid_i;
  logic [IdWidth-1:0] irq_id_i;
  logic               irq_ready_o;
  logic               core_irq_o;
  logic [IdWidth-1:0] core_irq_id_o;
  logic               core_ack_i;
  logic               core_done_i;
  logic               in_service_o;
  logic [IdWidth-1:0] active_id_o;
  logic               clear_stats_i;
  logic [31:0]        claim_cnt_o;
  logic [31:0]        withdraw_cnt_o;
  logic [31:0]        lat_max_o;

  int nerr   = 0;
  int nchecks = 0;

  edf_irq_claimer #(
    .NrIrqs (NrIrqs),
    .TsWidth(TsWidth)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mtime_i       (mtime_i),
    .irq_valid_i   (irq_valid_i),
    .irq_id_i      (irq_id_i),
    .irq_ready_o   (irq_ready_o),
    .core_irq_o    (core_irq_o),
    .core_irq_id_o (core_irq_id_o),
    .core_ack_i    (core_ack_i),
    .core_done_i   (core_done_i),
    .in_service_o  (in_service_o),
    .active_id_o   (active_id_o),
    .clear_stats_i (clear_stats_i),
    .claim_cnt_o   (claim_cnt_o),
    .withdraw_cnt_o(withdraw_cnt_o),
    .lat_max_o     (lat_max_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, ".core_irq"}, 64'(core_irq_o), 64'd0);
    chk({tag, ".irq_ready"}, 64'(irq_ready_o), 64'd0);
    chk({tag, ".in_service"}, 64'(in_service_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; mtime_i = '0; irq_valid_i = 1'b0; irq_id_i = '0;
    core_ack_i = 1'b0; core_done_i = 1'b0; clear_stats_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Reset state
    chk_idle_outs("reset");
    chk("reset.core_irq_id", 64'(core_irq_id_o), 64'd0);
    chk("reset.active_id", 64'(active_id_o), 64'd0);
    chk("reset.claim_cnt", 64'(claim_cnt_o), 64'd0);
    chk("reset.withdraw_cnt", 64'(withdraw_cnt_o), 64'd0);
    chk("reset.lat_max", 64'(lat_max_o), 64'd0);

    // Basic claim: arrive at 100, ack at 110
    irq_valid_i = 1'b1; irq_id_i = 2'd2; mtime_i = 64'd100;
    tick();
    chk("basic.core_irq", 64'(core_irq_o), 64'd1);
    chk("basic.core_irq_id", 64'(core_irq_id_o), 64'd2);
    chk("basic.no_ready", 64'(irq_ready_o), 64'd0);
    mtime_i = 64'd110; core_ack_i = 1'b1;
    tick();
    chk("basic.ready", 64'(irq_ready_o), 64'd1);
    chk("basic.core_irq_drop", 64'(core_irq_o), 64'd0);
    chk("basic.in_service", 64'(in_service_o), 64'd1);
    chk("basic.active_id", 64'(active_id_o), 64'd2);
    chk("basic.lat_max", 64'(lat_max_o), 64'd10);
    core_ack_i = 1'b0; irq_valid_i = 1'b0;
    tick();
    chk("basic.ready_single", 64'(irq_ready_o), 64'd0);
    chk("basic.service", 64'(in_service_o), 64'd1);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk("basic.done_in_service", 64'(in_service_o), 64'd0);
    chk("basic.claim_cnt", 64'(claim_cnt_o), 64'd1);

    // Re-arbitration: 2 -> 0 in PEND, latency from original entry (200 -> 230)
    irq_valid_i = 1'b1; irq_id_i = 2'd2; mtime_i = 64'd200;
    tick();
    irq_id_i = 2'd0; mtime_i = 64'd205;
    tick();
    chk("rearb.core_irq_id", 64'(core_irq_id_o), 64'd0);
    irq_id_i = 2'd3; mtime_i = 64'd230; core_ack_i = 1'b1;
    tick();
    chk("rearb.active_id", 64'(active_id_o), 64'd0);
    chk("rearb.lat_max", 64'(lat_max_o), 64'd30);
    core_ack_i = 1'b0; irq_valid_i = 1'b0;
    tick();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk("rearb.claim_cnt", 64'(claim_cnt_o), 64'd2);

    // Withdrawal before ack
    irq_valid_i = 1'b1; irq_id_i = 2'd1; mtime_i = 64'd300;
    tick();
    irq_valid_i = 1'b0;
    tick();
    chk_idle_outs("withdraw");
    chk("withdraw.cnt", 64'(withdraw_cnt_o), 64'd1);
    tick();
    chk("withdraw.no_ready", 64'(irq_ready_o), 64'd0);

    // Valid drop with ack in the same cycle: ack wins
    irq_valid_i = 1'b1; irq_id_i = 2'd3; mtime_i = 64'd400;
    tick();
    irq_valid_i = 1'b0; core_ack_i = 1'b1; mtime_i = 64'd405;
    tick();
    chk("ackdrop.ready", 64'(irq_ready_o), 64'd1);
    chk("ackdrop.withdraw_cnt", 64'(withdraw_cnt_o), 64'd1);
    chk("ackdrop.active_id", 64'(active_id_o), 64'd3);
    chk("ackdrop.lat_max_kept", 64'(lat_max_o), 64'd30);
    core_ack_i = 1'b0;
    tick();
    // Spurious ack in SERVICE
    core_ack_i = 1'b1;
    tick();
    core_ack_i = 1'b0;
    chk("ack_in_service.in_service", 64'(in_service_o), 64'd1);
    chk("ack_in_service.ready", 64'(irq_ready_o), 64'd0);
    chk("ack_in_service.core_irq", 64'(core_irq_o), 64'd0);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk("ackdrop.claim_cnt", 64'(claim_cnt_o), 64'd3);

    // Spurious ack + done in IDLE
    core_ack_i = 1'b1; core_done_i = 1'b1;
    tick();
    core_ack_i = 1'b0; core_done_i = 1'b0;
    chk_idle_outs("spur_idle");
    chk("spur_idle.claim_cnt", 64'(claim_cnt_o), 64'd3);
    chk("spur_idle.withdraw_cnt", 64'(withdraw_cnt_o), 64'd1);

    // Spurious done in PEND, then done in CLAIM
    irq_valid_i = 1'b1; irq_id_i = 2'd1; mtime_i = 64'd500;
    tick();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk("done_in_pend.core_irq", 64'(core_irq_o), 64'd1);
    chk("done_in_pend.claim_cnt", 64'(claim_cnt_o), 64'd3);
    core_ack_i = 1'b1; mtime_i = 64'd502;
    tick();
    core_ack_i = 1'b0; irq_valid_i = 1'b0; core_done_i = 1'b1;
    tick();
    chk("done_in_claim.in_service", 64'(in_service_o), 64'd1);
    chk("done_in_claim.claim_cnt", 64'(claim_cnt_o), 64'd3);
    tick();
    core_done_i = 1'b0;
    chk("done_in_claim.later_cnt", 64'(claim_cnt_o), 64'd4);
    chk("done_in_claim.idle", 64'(in_service_o), 64'd0);

    // mtime wrap: FFFF_FFFF_FFFF_FFF0 -> 0x10 is 0x20 ticks
    irq_valid_i = 1'b1; irq_id_i = 2'd2; mtime_i = 64'hFFFF_FFFF_FFFF_FFF0;
    tick();
    mtime_i = 64'h10; core_ack_i = 1'b1;
    tick();
    core_ack_i = 1'b0; irq_valid_i = 1'b0;
    chk("wrap.lat_max", 64'(lat_max_o), 64'h20);
    tick();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;

    // Saturation: 0 -> 0x1_0000_0000
    irq_valid_i = 1'b1; mtime_i = 64'd0;
    tick();
    mtime_i = 64'h1_0000_0000; core_ack_i = 1'b1;
    tick();
    core_ack_i = 1'b0; irq_valid_i = 1'b0;
    chk("sat.lat_max", 64'(lat_max_o), 64'hFFFF_FFFF);
    tick();

    // Clear in same cycle as done: clear wins
    core_done_i = 1'b1; clear_stats_i = 1'b1;
    tick();
    core_done_i = 1'b0; clear_stats_i = 1'b0;
    chk("clear.claim_cnt", 64'(claim_cnt_o), 64'd0);
    chk("clear.withdraw_cnt", 64'(withdraw_cnt_o), 64'd0);
    chk("clear.lat_max", 64'(lat_max_o), 64'd0);
    chk("clear.fsm_idle", 64'(in_service_o), 64'd0);

    // Async reset in SERVICE
    irq_valid_i = 1'b1; irq_id_i = 2'd3; mtime_i = 64'd10;
    tick();
    mtime_i = 64'd17; core_ack_i = 1'b1;
    tick();
    core_ack_i = 1'b0; irq_valid_i = 1'b0;
    chk("pre_reset.lat_max", 64'(lat_max_o), 64'd7);
    tick();
    chk("pre_reset.in_service", 64'(in_service_o), 64'd1);
    #2 rst_i = 1'b1;
    #1;
    chk_idle_outs("async_reset");
    chk("async_reset.active_id", 64'(active_id_o), 64'd0);
    chk("async_reset.core_irq_id", 64'(core_irq_id_o), 64'd0);
    chk("async_reset.lat_max", 64'(lat_max_o), 64'd0);
    #1 rst_i = 1'b0;

    // Normal operation after reset
    irq_valid_i = 1'b1; irq_id_i = 2'd1; mtime_i = 64'd50;
    tick();
    chk("post_reset.core_irq", 64'(core_irq_o), 64'd1);
    chk("post_reset.core_irq_id", 64'(core_irq_id_o), 64'd1);
    mtime_i = 64'd53; core_ack_i = 1'b1;
    tick();
    core_ack_i = 1'b0; irq_valid_i = 1'b0;
    chk("post_reset.ready", 64'(irq_ready_o), 64'd1);
    chk("post_reset.active_id", 64'(active_id_o), 64'd1);
    chk("post_reset.lat_max", 64'(lat_max_o), 64'd3);
    tick();
    chk("post_reset.ready_single", 64'(irq_ready_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
